// File: rtl/alu_issue_queue_if.sv
// Handshake and ALU-side bus for alu_issue_queue.
// master = command producer / ALU / result consumer side, slave = the queue.
interface alu_issue_queue_if #(
  parameter int TAG_W = 4,
  parameter int CW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sel;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             alu_carry;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_result;
  logic             out_carry;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    fifo_count;

  modport master (
    output in_valid, in_sel, in_a, in_b, in_tag, alu_out, alu_carry, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_carry,
           out_tag, fifo_count
  );

  modport slave (
    input  in_valid, in_sel, in_a, in_b, in_tag, alu_out, alu_carry, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_carry,
           out_tag, fifo_count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO + sequencer feeding an external 8-bit ALU. One command is in
// flight at a time; its result is held on the result port until consumed.
module alu_issue_queue #(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1,
  parameter int TAG_W       = 4
) (
  input logic            clock,
  input logic            reset,
  alu_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef struct packed {
    logic [3:0]       sel;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  cmd_t             mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;   // extra bit distinguishes full from empty
  logic [CW-1:0]    count_q;
  state_t           state_q;
  logic [LW-1:0]    lat_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic [3:0]       alu_sel_q;
  logic             out_valid_q, out_carry_q;
  logic [7:0]       out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic in_ready, push, pop;
  cmd_t cmd_in, head;

  // Ready only looks at the registered count, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign pop      = (count_q != '0) &&
                    ((state_q == IDLE) || (state_q == HOLD && bus.out_ready));
  assign cmd_in   = '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.in_ready   = in_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.fifo_count = count_q;

  // FIFO storage; contents are don't-care until pushed, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue sequencer: pop -> wait ALU_LATENCY edges -> capture -> hold until consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      tag_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_tag_q    <= '0;
    end else begin
      if (pop) begin
        alu_a_q   <= head.a;
        alu_b_q   <= head.b;
        alu_sel_q <= head.sel;
        tag_q     <= head.tag;
        lat_q     <= LW'(ALU_LATENCY);
      end
      case (state_q)
        IDLE: if (pop) state_q <= WAIT;
        WAIT: begin
          lat_q <= lat_q - 1'b1;
          if (lat_q == LW'(1)) begin
            out_result_q <= bus.alu_out;
            out_carry_q  <= bus.alu_carry;
            out_tag_q    <= tag_q;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= pop ? WAIT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
